// File: rtl/audio_pkg.sv
// Shared constants and types for the I2S DAC transmit path.
package audio_pkg;
    localparam int unsigned DATA_WIDTH  = 24;
    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_t;
endpackage

// File: rtl/stereo_sample_fifo.sv
// Stereo sample FIFO: {left, right} entries, power-of-two depth, show-ahead read.
module stereo_sample_fifo #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic [2*DATA_WIDTH-1:0]       wdata_i,
    output logic [2*DATA_WIDTH-1:0]       rdata_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = 2 * DATA_WIDTH;

    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/i2s_dac_tx.sv
// I2S DAC serializer slaved to CODEC-driven BCLK/DACLRCK, fed from a stereo FIFO.
module i2s_dac_tx #(
    parameter int unsigned DATA_WIDTH = audio_pkg::DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         CLOCK_50,
    input  logic                         reset_n,
    input  logic                         write,
    input  logic [DATA_WIDTH-1:0]        writedata_left,
    input  logic [DATA_WIDTH-1:0]        writedata_right,
    output logic                         write_ready,
    output logic [$clog2(FIFO_DEPTH):0]  fill_level,
    output logic                         underflow,
    input  logic                         AUD_BCLK,
    input  logic                         AUD_DACLRCK,
    output logic                         AUD_DACDAT
);
    import audio_pkg::*;

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    logic [SYNC_STAGES-1:0]  bclk_sync_q;
    logic [SYNC_STAGES-1:0]  lrck_sync_q;
    logic                    bclk_dly_q;
    logic                    lr_prev_q;
    i2s_state_t              state_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [DATA_WIDTH-1:0]   hold_r_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic                    dacdat_q;
    logic                    underflow_q;

    logic                    bclk_fall_c;
    logic                    lr_now_c;
    logic                    left_edge_c;
    logic                    right_edge_c;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop_c;
    logic [2*DATA_WIDTH-1:0] fifo_rdata;

    // LRCK is judged against its value at the previous BCLK fall.
    assign bclk_fall_c  = bclk_dly_q & ~bclk_sync_q[SYNC_STAGES-1];
    assign lr_now_c     = lrck_sync_q[SYNC_STAGES-1];
    assign left_edge_c  = bclk_fall_c & (lr_now_c != lr_prev_q) & ~lr_now_c;
    assign right_edge_c = bclk_fall_c & (lr_now_c != lr_prev_q) &  lr_now_c;
    assign pop_c        = left_edge_c & ~fifo_empty;

    assign write_ready = ~fifo_full;
    assign underflow   = underflow_q;
    assign AUD_DACDAT  = dacdat_q;

    stereo_sample_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLOCK_50),
        .rst_n   (reset_n),
        .push_i  (write),
        .pop_i   (pop_c),
        .wdata_i ({writedata_left, writedata_right}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fill_level)
    );

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync_q <= '0;
            lrck_sync_q <= '0;
            bclk_dly_q  <= 1'b0;
            lr_prev_q   <= 1'b0;
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_r_q    <= '0;
            bit_cnt_q   <= '0;
            dacdat_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], AUD_BCLK};
            lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], AUD_DACLRCK};
            bclk_dly_q  <= bclk_sync_q[SYNC_STAGES-1];

            if (bclk_fall_c) begin
                lr_prev_q <= lr_now_c;
                // Frame edges always restart the word; the edge type picks the channel.
                if (left_edge_c) begin
                    state_q   <= LEFT;
                    bit_cnt_q <= '0;
                    dacdat_q  <= 1'b0;
                    if (!fifo_empty) begin
                        shift_q  <= fifo_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
                        hold_r_q <= fifo_rdata[DATA_WIDTH-1:0];
                    end else begin
                        shift_q     <= '0;
                        hold_r_q    <= '0;
                        underflow_q <= 1'b1;
                    end
                end else if (right_edge_c && state_q != IDLE) begin
                    state_q   <= RIGHT;
                    shift_q   <= hold_r_q;
                    bit_cnt_q <= '0;
                    dacdat_q  <= 1'b0;
                end else if (state_q != IDLE && bit_cnt_q < CNT_W'(DATA_WIDTH)) begin
                    dacdat_q  <= shift_q[DATA_WIDTH-1];
                    shift_q   <= {shift_q[DATA_WIDTH-2:0], 1'b0};
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                end else begin
                    dacdat_q <= 1'b0;
                end
            end
        end
    end
endmodule
